// File: rtl/lcd_ctrl.sv
// lcd_ctrl -- HD44780 write-cycle sequencer driven by the 32-bit LCD output
// register (io_lcd). Each toggle of io_lcd[10] is one command. It is played out as:
//   RS/DATA setup -> E pulse -> hold -> execution wait.
// A single-entry pending slot absorbs one command while another is in flight.
// Further commands are dropped, and the sticky overflow flag is set.
//
// Optional build macro: LCD_CTRL_INIT_EN. When defined, a power-up
// sequencer waits 2^20 cycles after reset. It then issues 0x38, 0x0C, 0x01,
// 0x06 (RS=0) through the same timing FSM before software commands run.
//
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   io_lcd_i    [31] ON, [10] REQ toggle, [9] RS, [8] RW (ignored), [7:0] DATA
//   lcd_on_o    registered copy of io_lcd_i[31]
//   lcd_rs_o    register select of the active command
//   lcd_rw_o    always 0 (write only)
//   lcd_en_o    E strobe, driven straight from a flop
//   lcd_data_o  data bus of the active command
//   busy_o      command in flight or pending (or init running)
//   status_o    {29'b0, ovf, pend_vld, busy}
module lcd_ctrl #(
  parameter int unsigned T_AS_CYC   = 4,
  parameter int unsigned T_PW_CYC   = 16,
  parameter int unsigned T_H_CYC    = 4,
  parameter int unsigned T_EXEC_CYC = 2000,
  parameter int unsigned T_CLR_CYC  = 80000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] io_lcd_i,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o,
  output logic        busy_o,
  output logic [31:0] status_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  // The down-counter is loaded with (duration - 1) on state entry.
  // The state is left on the edge where the counter reads zero.
  localparam logic [16:0] AS_LD   = 17'(T_AS_CYC - 1);
  localparam logic [16:0] PW_LD   = 17'(T_PW_CYC - 1);
  localparam logic [16:0] H_LD    = 17'(T_H_CYC - 1);
  localparam logic [16:0] EXEC_LD = 17'(T_EXEC_CYC - 1);
  localparam logic [16:0] CLR_LD  = 17'(T_CLR_CYC - 1);

  state_t      state_reg, state_next;
  logic [16:0] cnt_reg, cnt_next;
  logic        act_rs_reg, act_rs_next;
  logic [7:0]  act_data_reg, act_data_next;
  logic        pend_rs_reg, pend_rs_next;
  logic [7:0]  pend_data_reg, pend_data_next;
  logic        pend_vld_reg, pend_vld_next;
  logic        ovf_reg, ovf_next;
  logic        req_prev_reg;
  logic        en_reg;
  logic        on_reg;

  logic        req_evt;
  logic        cnt_done;
  logic        slot_free;
  logic [16:0] wait_ld;
  logic        init_busy;
  logic        init_go;
  logic        init_take;
  logic [7:0]  init_data;
  logic        lcd_unused;

  assign req_evt  = io_lcd_i[10] ^ req_prev_reg;
  assign cnt_done = (cnt_reg == 17'd0);

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign wait_ld = (!act_rs_reg && (act_data_reg[7:2] == 6'd0)) ? CLR_LD : EXEC_LD;

  // The FSM can take a new active command on this edge.
  // This holds when it is idle, or when the current command's final wait cycle is ending.
  // The init sequence has priority while it still has commands to issue.
  assign slot_free = !init_busy &&
                     ((state_reg == S_IDLE) || ((state_reg == S_WAIT) && cnt_done));

`ifdef LCD_CTRL_INIT_EN
  logic [20:0] pwr_cnt_reg;
  logic [2:0]  init_idx_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pwr_cnt_reg  <= 21'd0;
      init_idx_reg <= 3'd0;
    end else begin
      // Bit 20 sets after exactly 2^20 cycles and then freezes the count.
      if (!pwr_cnt_reg[20]) begin
        pwr_cnt_reg <= pwr_cnt_reg + 21'd1;
      end
      if (init_take) begin
        init_idx_reg <= init_idx_reg + 3'd1;
      end
    end
  end

  assign init_busy = (init_idx_reg != 3'd4);
  assign init_go   = init_busy && pwr_cnt_reg[20] && (state_reg == S_IDLE);

  always_comb begin
    init_data = 8'h06;
    case (init_idx_reg[1:0])
      2'd0:    init_data = 8'h38;
      2'd1:    init_data = 8'h0C;
      2'd2:    init_data = 8'h01;
      default: init_data = 8'h06;
    endcase
  end

  assign lcd_unused = ^{io_lcd_i[30:11], io_lcd_i[8]};
`else
  assign init_busy  = 1'b0;
  assign init_go    = 1'b0;
  assign init_data  = 8'h00;
  assign lcd_unused = ^{io_lcd_i[30:11], io_lcd_i[8], init_take};
`endif

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    act_rs_next    = act_rs_reg;
    act_data_next  = act_data_reg;
    pend_rs_next   = pend_rs_reg;
    pend_data_next = pend_data_reg;
    pend_vld_next  = pend_vld_reg;
    ovf_next       = ovf_reg;
    init_take      = 1'b0;

    case (state_reg)
      S_SETUP: begin
        if (cnt_done) begin
          state_next = S_PULSE;
          cnt_next   = PW_LD;
        end else begin
          cnt_next = cnt_reg - 17'd1;
        end
      end
      S_PULSE: begin
        if (cnt_done) begin
          state_next = S_HOLD;
          cnt_next   = H_LD;
        end else begin
          cnt_next = cnt_reg - 17'd1;
        end
      end
      S_HOLD: begin
        if (cnt_done) begin
          state_next = S_WAIT;
          cnt_next   = wait_ld;
        end else begin
          cnt_next = cnt_reg - 17'd1;
        end
      end
      S_WAIT: begin
        if (cnt_done) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - 17'd1;
        end
      end
      default: begin
        if (init_go) begin
          state_next    = S_SETUP;
          cnt_next      = AS_LD;
          act_rs_next   = 1'b0;
          act_data_next = init_data;
          init_take     = 1'b1;
        end
      end
    endcase

    // A pending command advances first, so the next command starts with no idle gap.
    if (slot_free && pend_vld_reg) begin
      state_next    = S_SETUP;
      cnt_next      = AS_LD;
      act_rs_next   = pend_rs_reg;
      act_data_next = pend_data_reg;
      pend_vld_next = 1'b0;
    end

    if (req_evt) begin
      if (slot_free && !pend_vld_reg) begin
        state_next    = S_SETUP;
        cnt_next      = AS_LD;
        act_rs_next   = io_lcd_i[9];
        act_data_next = io_lcd_i[7:0];
      end else if (slot_free || !pend_vld_reg) begin
        // When slot_free is true here, the pending slot was just vacated above.
        pend_rs_next   = io_lcd_i[9];
        pend_data_next = io_lcd_i[7:0];
        pend_vld_next  = 1'b1;
      end else begin
        ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 17'd0;
      act_rs_reg    <= 1'b0;
      act_data_reg  <= 8'h00;
      pend_rs_reg   <= 1'b0;
      pend_data_reg <= 8'h00;
      pend_vld_reg  <= 1'b0;
      ovf_reg       <= 1'b0;
      req_prev_reg  <= 1'b0;
      en_reg        <= 1'b0;
      on_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      act_rs_reg    <= act_rs_next;
      act_data_reg  <= act_data_next;
      pend_rs_reg   <= pend_rs_next;
      pend_data_reg <= pend_data_next;
      pend_vld_reg  <= pend_vld_next;
      ovf_reg       <= ovf_next;
      req_prev_reg  <= io_lcd_i[10];
      // E is registered from the next state, so it is high exactly during PULSE.
      en_reg        <= (state_next == S_PULSE);
      on_reg        <= io_lcd_i[31];
    end
  end

  assign busy_o     = (state_reg != S_IDLE) | pend_vld_reg | init_busy;
  assign status_o   = {29'd0, ovf_reg, pend_vld_reg, busy_o};
  assign lcd_on_o   = on_reg;
  assign lcd_rs_o   = act_rs_reg;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_reg;
  assign lcd_data_o = act_data_reg;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Testbench for lcd_ctrl. It uses shortened wait parameters so that the run stays short.
// A command-queue reference model predicts every output on every cycle.
module tb_lcd_ctrl;

  localparam int T_AS   = 4;
  localparam int T_PW   = 16;
  localparam int T_H    = 4;
  localparam int T_EXEC = 200;
  localparam int T_CLR  = 1000;
  localparam int D_NORM = T_AS + T_PW + T_H + T_EXEC;
  localparam int D_CLR  = T_AS + T_PW + T_H + T_CLR;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] io_lcd_i = 32'd0;
  logic        lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, busy_o;
  logic [7:0]  lcd_data_o;
  logic [31:0] status_o;

  always #5 clk_i = ~clk_i;

  lcd_ctrl #(
    .T_AS_CYC  (T_AS),
    .T_PW_CYC  (T_PW),
    .T_H_CYC   (T_H),
    .T_EXEC_CYC(T_EXEC),
    .T_CLR_CYC (T_CLR)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .io_lcd_i  (io_lcd_i),
    .lcd_on_o  (lcd_on_o),
    .lcd_rs_o  (lcd_rs_o),
    .lcd_rw_o  (lcd_rw_o),
    .lcd_en_o  (lcd_en_o),
    .lcd_data_o(lcd_data_o),
    .busy_o    (busy_o),
    .status_o  (status_o)
  );

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } cmd_t;

  // Reference model: q[0] is the command being played out, and q[1] is the pending command.
  cmd_t q[$];
  int   cyc = 0;
  int   head_start = 0;
  logic m_ovf = 1'b0;
  logic m_on = 1'b0;
  logic m_req_prev = 1'b0;
  cmd_t m_last = '0;
  cmd_t m_cmd;
  logic m_evt;

  int checks = 0;
  int errors = 0;

  function automatic int dur(cmd_t c);
    return T_AS + T_PW + T_H + ((!c.rs && c.data < 8'h04) ? T_CLR : T_EXEC);
  endfunction

  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (!rst_ni) begin
      q.delete();
      m_ovf      = 1'b0;
      m_on       = 1'b0;
      m_req_prev = 1'b0;
      m_last     = '0;
    end else begin
      m_on       = io_lcd_i[31];
      m_evt      = io_lcd_i[10] ^ m_req_prev;
      m_req_prev = io_lcd_i[10];
      m_cmd.rs   = io_lcd_i[9];
      m_cmd.data = io_lcd_i[7:0];
      if (q.size() > 0 && cyc == head_start + dur(q[0])) begin
        void'(q.pop_front());
        if (q.size() > 0) begin
          head_start = cyc;
          m_last     = q[0];
        end
      end
      if (m_evt) begin
        if (q.size() == 0) begin
          q.push_back(m_cmd);
          head_start = cyc;
          m_last     = m_cmd;
        end else if (q.size() == 1) begin
          q.push_back(m_cmd);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  function automatic logic [44:0] exp_vec();
    logic m_busy, m_en;
    int   off;
    m_busy = (q.size() > 0);
    off    = cyc - head_start;
    m_en   = m_busy && off >= T_AS && off < T_AS + T_PW;
    return {m_on, m_last.rs, 1'b0, m_en, m_last.data, m_busy,
            29'd0, m_ovf, (q.size() == 2), m_busy};
  endfunction

  function automatic logic [44:0] obs_vec();
    return {lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o, busy_o, status_o};
  endfunction

  task automatic toggle(input logic rs, input logic [7:0] data);
    io_lcd_i[10]  = ~io_lcd_i[10];
    io_lcd_i[9]   = rs;
    io_lcd_i[7:0] = data;
  endtask

  task automatic test_reset();
    io_lcd_i = 32'h8000_0000;
    rst_ni   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== 45'd0) begin
        errors++;
        $display("FAIL reset cyc %0d: got %h expected %h", i, obs_vec(), 45'd0);
      end
    end
    io_lcd_i = 32'd0;
    rst_ni   = 1'b1;
    $display("reset: %0d cycles held, outputs checked zero", 4);
  endtask

  task automatic test_single();
    int en_first = -1, en_cnt = 0, busy_cnt = 0;
    toggle(1'b1, 8'h41);
    for (int i = 1; i <= D_NORM + 20; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (lcd_en_o && en_first < 0) en_first = i;
      if (lcd_en_o) en_cnt++;
      if (busy_o) busy_cnt++;
    end
    checks++;
    if (en_first !== T_AS + 1 || en_cnt !== T_PW || busy_cnt !== D_NORM) begin
      errors++;
      $display("FAIL single_timing: got en_first=%0d en_cnt=%0d busy=%0d expected %0d %0d %0d",
               en_first, en_cnt, busy_cnt, T_AS + 1, T_PW, D_NORM);
    end
    $display("single 0x41: en_first=%0d en_cnt=%0d busy=%0d", en_first, en_cnt, busy_cnt);
  endtask

  task automatic test_clear();
    int busy_cnt = 0, rw_cnt = 0;
    toggle(1'b0, 8'h01);
    for (int i = 1; i <= D_CLR + 20; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL clear cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (busy_o) busy_cnt++;
      if (lcd_rw_o !== 1'b0) rw_cnt++;
    end
    checks++;
    if (busy_cnt !== D_CLR || rw_cnt !== 0) begin
      errors++;
      $display("FAIL clear_timing: got busy=%0d rw_hi=%0d expected %0d 0", busy_cnt, rw_cnt, D_CLR);
    end
    $display("clear 0x01: busy=%0d", busy_cnt);
  endtask

  task automatic test_overflow();
    int pulses = 0, busy_cnt = 0;
    logic en_d = 1'b0;
    for (int i = 0; i < 2 * D_NORM + 40; i++) begin
      if (i == 0)  toggle(1'b1, 8'h41);
      if (i == 10) toggle(1'b1, 8'h42);
      if (i == 20) toggle(1'b1, 8'h43);
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL overflow cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (lcd_en_o && !en_d) pulses++;
      en_d = lcd_en_o;
      if (busy_o) busy_cnt++;
    end
    checks++;
    if (status_o !== 32'h4 || pulses !== 2 || busy_cnt !== 2 * D_NORM) begin
      errors++;
      $display("FAIL overflow_end: got status=%h pulses=%0d busy=%0d expected 00000004 2 %0d",
               status_o, pulses, busy_cnt, 2 * D_NORM);
    end
    $display("overflow: status=%h pulses=%0d busy=%0d", status_o, pulses, busy_cnt);
  endtask

  task automatic test_reset_mid();
    int en_cnt = 0;
    toggle(1'b1, 8'h55);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_pre cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (lcd_en_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_in_pulse: got en=%b expected 1", lcd_en_o);
    end
    rst_ni   = 1'b0;
    io_lcd_i = 32'd0;
    @(negedge clk_i);
    checks++;
    if (lcd_en_o !== 1'b0 || status_o !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_drop: got en=%b status=%h expected 0 00000000", lcd_en_o, status_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_quiet cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (lcd_en_o) en_cnt++;
    end
    toggle(1'b1, 8'h66);
    for (int i = 1; i <= D_NORM + 10; i++) begin
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_fresh cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (lcd_en_o) en_cnt++;
    end
    checks++;
    if (en_cnt !== T_PW) begin
      errors++;
      $display("FAIL rstmid_pulses: got en_cnt=%0d expected %0d", en_cnt, T_PW);
    end
    $display("reset_mid: en cycles after reset=%0d", en_cnt);
  endtask

  task automatic test_coincident();
    int pulses = 0, ovf_seen = 0;
    logic en_d = 1'b0;
    for (int i = 0; i < 3 * D_NORM + 40; i++) begin
      if (i == 0)      toggle(1'b1, 8'h30);
      if (i == 10)     toggle(1'b1, 8'h31);
      if (i == D_NORM) toggle(1'b1, 8'h32);  // lands on the final WAIT edge of 0x30
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL coincident cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (lcd_en_o && !en_d) pulses++;
      en_d = lcd_en_o;
      if (status_o[2]) ovf_seen++;
    end
    checks++;
    if (pulses !== 3 || ovf_seen !== 0 || status_o !== 32'd0) begin
      errors++;
      $display("FAIL coincident_end: got pulses=%0d ovf_cycles=%0d status=%h expected 3 0 00000000",
               pulses, ovf_seen, status_o);
    end
    $display("coincident: pulses=%0d status=%h", pulses, status_o);
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic        tog;
    int          n_tog = 0;
    for (int i = 0; i < 4000; i++) begin
      r   = $urandom;
      tog = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) r[7:0] = 8'($urandom_range(0, 3));
      r[10]    = tog ? ~io_lcd_i[10] : io_lcd_i[10];
      io_lcd_i = r;
      rst_ni   = ($urandom_range(0, 999) != 0);
      if (tog) n_tog++;
      @(negedge clk_i);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    rst_ni = 1'b1;
    $display("random: 4000 cycles, %0d toggles", n_tog);
  endtask

  initial begin
    test_reset();
    test_single();
    test_clear();
    test_overflow();
    test_reset_mid();
    test_coincident();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
